// File: rtl/rms_feeder_pkg.sv
// Shared types and sizing for the RMS feeder that sits in front of the
// Newton square-root block.
package rms_feeder_pkg;

    localparam int unsigned SQ_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StWaitAvail,
        StBusy,
        StRelease
    } feed_state_e;

    // Wide enough to sum 2^log2n worst-case squares without overflow.
    function automatic int unsigned acc_width(input int unsigned sample_w,
                                              input int unsigned log2n);
        return 2 * sample_w - 1 + log2n;
    endfunction

endpackage

// File: rtl/sq_window_acc.sv
// Squares incoming samples, sums them over a 2^LOG2N window and holds the
// window mean until the feed FSM releases it through mean_free_i.
module sq_window_acc
    import rms_feeder_pkg::*;
#(
    parameter int unsigned LOG2N    = 4,
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    input  logic signed [SAMPLE_W-1:0] s_data_i,
    output logic [SQ_W-1:0]            mean_o,
    output logic                       mean_valid_o,
    input  logic                       mean_free_i
);

    localparam int unsigned SqW  = 2 * SAMPLE_W - 1;
    localparam int unsigned AccW = acc_width(SAMPLE_W, LOG2N);
    localparam int unsigned CntW = (LOG2N > 0) ? LOG2N : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((1 << LOG2N) - 1);

    logic [SAMPLE_W-1:0] mag;
    logic [SqW-1:0]      sq;
    logic [AccW-1:0]     sum;
    logic [AccW-1:0]     acc_q, acc_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [SQ_W-1:0]     mean_q, mean_d;
    logic                mean_valid_q, mean_valid_d;
    logic                last;
    logic                fire;

    // Only the window-closing sample needs the mean register, so only it stalls.
    assign last      = (cnt_q == CntLast);
    assign s_ready_o = !(last && mean_valid_q);
    assign fire      = s_valid_i && s_ready_o;

    always_comb begin
        // Magnitude of the most negative sample still fits as an unsigned value.
        mag          = s_data_i[SAMPLE_W-1] ? -s_data_i : s_data_i;
        sq           = SqW'(mag) * SqW'(mag);
        sum          = acc_q + AccW'(sq);
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        mean_d       = mean_q;
        mean_valid_d = mean_valid_q;
        if (mean_free_i) begin
            mean_valid_d = 1'b0;
        end
        if (fire) begin
            if (last) begin
                acc_d        = '0;
                cnt_d        = '0;
                mean_d       = SQ_W'(sum >> LOG2N);
                mean_valid_d = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            mean_q       <= '0;
            mean_valid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            mean_q       <= mean_d;
            mean_valid_q <= mean_valid_d;
        end
    end

    assign mean_o       = mean_q;
    assign mean_valid_o = mean_valid_q;

endmodule

// File: rtl/rms_sqrt_feeder.sv
// Windowed mean-square front end: feeds each window mean to the square-root
// block over its START/AVAILABLE/DONE handshake and reports one RMS per window.
module rms_sqrt_feeder
    import rms_feeder_pkg::*;
#(
    parameter int unsigned LOG2N    = 4,
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [SAMPLE_W-1:0] s_data,
    output logic [SQ_W-1:0]            sq_in,
    output logic                       sq_start,
    input  logic                       sq_available,
    input  logic                       sq_done,
    input  logic [SQ_W-1:0]            sq_out,
    output logic [SQ_W-1:0]            rms,
    output logic                       rms_valid
);

    feed_state_e     state_q, state_d;
    logic            sq_start_q, sq_start_d;
    logic [SQ_W-1:0] rms_q, rms_d;
    logic            rms_valid_q, rms_valid_d;
    logic [SQ_W-1:0] mean;
    logic            mean_valid;
    logic            mean_free;

    sq_window_acc #(
        .LOG2N    (LOG2N),
        .SAMPLE_W (SAMPLE_W)
    ) u_acc (
        .clk_i        (clk),
        .rst_ni       (rstn),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .s_data_i     (s_data),
        .mean_o       (mean),
        .mean_valid_o (mean_valid),
        .mean_free_i  (mean_free)
    );

    always_comb begin
        state_d     = state_q;
        sq_start_d  = sq_start_q;
        rms_d       = rms_q;
        rms_valid_d = 1'b0;
        mean_free   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mean_valid) begin
                    // A zero operand would divide by zero inside the Newton block.
                    if (mean == '0) begin
                        rms_d       = '0;
                        rms_valid_d = 1'b1;
                        mean_free   = 1'b1;
                    end else begin
                        state_d = StWaitAvail;
                    end
                end
            end
            StWaitAvail: begin
                // A lingering DONE means the block has not really returned to ready.
                if (sq_available && !sq_done) begin
                    sq_start_d = 1'b1;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                if (sq_done) begin
                    rms_d       = sq_out;
                    rms_valid_d = 1'b1;
                    sq_start_d  = 1'b0;
                    state_d     = StRelease;
                end
            end
            StRelease: begin
                if (!sq_done) begin
                    mean_free = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            sq_start_q  <= 1'b0;
            rms_q       <= '0;
            rms_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sq_start_q  <= sq_start_d;
            rms_q       <= rms_d;
            rms_valid_q <= rms_valid_d;
        end
    end

    assign sq_in     = mean;
    assign sq_start  = sq_start_q;
    assign rms       = rms_q;
    assign rms_valid = rms_valid_q;

endmodule

// File: tb/tb_rms_sqrt_feeder.sv
// Directed bench for rms_sqrt_feeder with a behavioural Newton square-root
// block model (configurable latency and DONE hold-over).
module tb_rms_sqrt_feeder;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic signed [15:0] s_data = '0;
    logic [31:0]        sq_in;
    logic               sq_start;
    logic               sq_available;
    logic               sq_done;
    logic [31:0]        sq_out;
    logic [31:0]        rms;
    logic               rms_valid;

    logic               big_valid = 1'b0;
    logic signed [15:0] big_data = '0;
    logic               big_ready;
    logic [31:0]        big_sq_in;
    logic               big_start;
    logic [31:0]        big_rms;
    logic               big_rms_valid;

    always #5 clk = ~clk;

    rms_sqrt_feeder #(
        .LOG2N    (2),
        .SAMPLE_W (16)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .sq_in        (sq_in),
        .sq_start     (sq_start),
        .sq_available (sq_available),
        .sq_done      (sq_done),
        .sq_out       (sq_out),
        .rms          (rms),
        .rms_valid    (rms_valid)
    );

    rms_sqrt_feeder #(
        .LOG2N    (8),
        .SAMPLE_W (16)
    ) dut_big (
        .clk          (clk),
        .rstn         (rstn),
        .s_valid      (big_valid),
        .s_ready      (big_ready),
        .s_data       (big_data),
        .sq_in        (big_sq_in),
        .sq_start     (big_start),
        .sq_available (1'b0),
        .sq_done      (1'b0),
        .sq_out       (32'h0),
        .rms          (big_rms),
        .rms_valid    (big_rms_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // floor(sqrt(x << 32)), i.e. a 16.16 square root.
    function automatic logic [31:0] isqrt_q16(input logic [31:0] x);
        logic [63:0] v;
        logic [31:0] r;
        logic [31:0] t;
        v = {x, 32'h0};
        r = '0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (32'h1 << b);
            if ({32'h0, t} * {32'h0, t} <= v) r = t;
        end
        return r;
    endfunction

    // Square-root block model: 0 idle, 1 computing, 2 DONE with START high, 3 stale DONE.
    int          lat  = 13;
    int          hold = 0;
    int          m_st = 0;
    int          m_cnt = 0;
    int          m_hold = 0;
    logic [31:0] m_op = '0;
    logic        m_avail = 1'b1;
    logic        m_done = 1'b0;
    logic [31:0] m_out = '0;

    assign sq_available = m_avail;
    assign sq_done      = m_done;
    assign sq_out       = m_out;

    always @(posedge clk) begin
        case (m_st)
            0: if (sq_start) begin
                m_op    <= sq_in;
                m_cnt   <= lat - 1;
                m_avail <= 1'b0;
                m_st    <= 1;
            end
            1: if (m_cnt == 0) begin
                m_done <= 1'b1;
                m_out  <= isqrt_q16(m_op);
                m_st   <= 2;
            end else begin
                m_cnt <= m_cnt - 1;
            end
            2: if (!sq_start) begin
                m_avail <= 1'b1;
                if (hold == 0) begin
                    m_done <= 1'b0;
                    m_st   <= 0;
                end else begin
                    m_hold <= hold - 1;
                    m_st   <= 3;
                end
            end
            default: if (m_hold == 0) begin
                m_done <= 1'b0;
                m_st   <= 0;
            end else begin
                m_hold <= m_hold - 1;
            end
        endcase
    end

    logic        prev_start = 1'b0;
    logic        prev_done = 1'b0;
    int          viol = 0;
    int          starts = 0;
    int          rv_pulses = 0;
    logic [31:0] rms_hist[$];

    always @(negedge clk) begin
        if (sq_start && !prev_start) begin
            starts <= starts + 1;
            if (prev_done) viol <= viol + 1;
        end
        if (rms_valid) begin
            rv_pulses <= rv_pulses + 1;
            rms_hist.push_back(rms);
        end
        prev_start <= sq_start;
        prev_done  <= sq_done;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Presents one sample and returns the cycle after it transfers; s_valid stays high.
    task automatic push(input logic signed [15:0] d, output int stalls);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: s_ready still 0 after %0d cycles, required 1", n);
        end
        tick();
        stalls = n;
    endtask

    task automatic wait_pulses(input int target, input string name);
        int n;
        n = 0;
        while (rv_pulses < target && n < 1000) begin
            tick();
            n++;
        end
        check(name, 32'(rv_pulses), 32'(target));
    endtask

    typedef struct {
        logic signed [15:0] s[4];
        logic [31:0]        mean;
        logic [31:0]        rms;
        int                 starts;
    } vec_t;

    vec_t vecs[7];

    task automatic set_vec(input int i, input int a, input int b, input int c, input int d,
                           input logic [31:0] mean, input logic [31:0] r, input int st);
        vecs[i].s[0]   = 16'(a);
        vecs[i].s[1]   = 16'(b);
        vecs[i].s[2]   = 16'(c);
        vecs[i].s[3]   = 16'(d);
        vecs[i].mean   = mean;
        vecs[i].rms    = r;
        vecs[i].starts = st;
    endtask

    task automatic run_vec(input int i);
        int st0;
        int pv0;
        int dummy;
        st0 = starts;
        pv0 = rv_pulses;
        for (int k = 0; k < 4; k++) push(vecs[i].s[k], dummy);
        s_valid = 1'b0;
        wait_pulses(pv0 + 1, $sformatf("v%0d_rms_valid", i));
        check($sformatf("v%0d_rms", i), rms, vecs[i].rms);
        check($sformatf("v%0d_sq_in", i), sq_in, vecs[i].mean);
        check($sformatf("v%0d_starts", i), 32'(starts - st0), 32'(vecs[i].starts));
        tick();
        check($sformatf("v%0d_pulse_width", i), 32'(rms_valid), 32'h0);
    endtask

    initial begin
        int n;
        int pv0;
        int st0;
        int base;
        int stall_bad;
        int stall_seen;
        int not_ready;
        int sel[3];

        set_vec(0, 100, -100, 100, -100, 32'd10000, 32'h0064_0000, 1);
        set_vec(1, 0, 0, 0, 0, 32'd0, 32'h0, 0);
        set_vec(2, 1, 2, 3, 4, 32'd7, 32'h0002_A54F, 1);
        set_vec(3, -8192, -8192, -8192, -8192, 32'h0400_0000, 32'h2000_0000, 1);
        set_vec(4, 3, 0, 0, 0, 32'd2, 32'h0001_6A09, 1);
        set_vec(5, 1, 1, 1, 0, 32'd0, 32'h0, 0);
        set_vec(6, 2, -2, 2, -2, 32'd4, 32'h0002_0000, 1);

        tick();
        tick();
        check("rst_s_ready", 32'(s_ready), 32'h1);
        check("rst_sq_start", 32'(sq_start), 32'h0);
        check("rst_sq_in", sq_in, 32'h0);
        check("rst_rms", rms, 32'h0);
        check("rst_rms_valid", 32'(rms_valid), 32'h0);
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_vec(i);

        // Zero mean bypasses the square root; rms_valid two cycles after closing sample.
        st0 = starts;
        for (int k = 0; k < 3; k++) push(16'sd0, n);
        s_data = 16'sd0;
        check("zero_close_ready", 32'(s_ready), 32'h1);
        tick();
        s_valid = 1'b0;
        check("zero_rv_c1", 32'(rms_valid), 32'h0);
        tick();
        check("zero_rv_c2", 32'(rms_valid), 32'h1);
        check("zero_rms", rms, 32'h0);
        tick();
        check("zero_rv_c3", 32'(rms_valid), 32'h0);
        check("zero_no_start", 32'(starts - st0), 32'h0);

        // Continuous input against a slow block: only closing samples may stall.
        for (int k = 0; k < 5; k++) tick();
        lat        = 40;
        base       = rms_hist.size();
        pv0        = rv_pulses;
        stall_bad  = 0;
        stall_seen = 0;
        sel[0] = 0;
        sel[1] = 2;
        sel[2] = 6;
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 4; k++) begin
                push(vecs[sel[w]].s[k], n);
                if (n > 0) begin
                    if (k == 3) stall_seen++;
                    else stall_bad++;
                end
            end
        end
        s_valid = 1'b0;
        wait_pulses(pv0 + 3, "cont_rms_valid");
        check("cont_bad_stalls", 32'(stall_bad), 32'h0);
        check("cont_closing_stalls", 32'(stall_seen), 32'h2);
        for (int w = 0; w < 3; w++) begin
            if (rms_hist.size() > base + w)
                check($sformatf("cont_rms%0d", w), rms_hist[base + w], vecs[sel[w]].rms);
            else
                check($sformatf("cont_rms%0d_missing", w), 32'(rms_hist.size()), 32'(base + 3));
        end

        // Reset during BUSY with a stale-DONE block, then a clean window.
        for (int k = 0; k < 60; k++) tick();
        lat  = 13;
        hold = 3;
        for (int k = 0; k < 4; k++) push(vecs[0].s[k], n);
        push(16'sd1000, n);
        push(16'sd1000, n);
        s_valid = 1'b0;
        n = 0;
        while (!sq_start && n < 50) begin
            tick();
            n++;
        end
        check("rstbusy_started", 32'(sq_start), 32'h1);
        tick();
        tick();
        tick();
        pv0  = rv_pulses;
        rstn = 1'b0;
        #1;
        check("rstbusy_sq_start", 32'(sq_start), 32'h0);
        check("rstbusy_rms_valid", 32'(rms_valid), 32'h0);
        check("rstbusy_sq_in", sq_in, 32'h0);
        check("rstbusy_s_ready", 32'(s_ready), 32'h1);
        tick();
        rstn = 1'b1;
        tick();
        check("rstbusy_no_pulse", 32'(rv_pulses), 32'(pv0));
        run_vec(2);
        run_vec(6);
        check("start_while_done", 32'(viol), 32'h0);

        // Full-scale negative samples over a 256-sample window.
        not_ready = 0;
        for (int k = 0; k < 256; k++) begin
            big_valid = 1'b1;
            big_data  = 16'h8000;
            if (!big_ready) not_ready++;
            if (k == 255) check("big_sq_in_pre", big_sq_in, 32'h0);
            tick();
        end
        big_valid = 1'b0;
        check("big_sq_in", big_sq_in, 32'h4000_0000);
        check("big_never_stalled", 32'(not_ready), 32'h0);
        tick();
        tick();
        check("big_no_start", 32'(big_start), 32'h0);
        check("big_no_rms_valid", 32'(big_rms_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
